// File: rtl/mem_arbiter_fsm.sv
// Purpose: shares one cacheline port of the burst adaptor between the I-side and D-side caches.
// Latency: request sampled in IDLE, downstream request from next cycle, owner resp 1 cycle after mmem_resp.
// Backpressure: requesters hold their request until resp; the loser waits, with a starvation bound on fixed priority.
module mem_arbiter_fsm #(
    parameter int LINE_W       = 256,
    parameter int ADDR_W       = 32,
    parameter int PRIO_D       = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              imem_read,
    input  logic              imem_write,
    input  logic [ADDR_W-1:0] imem_address,
    input  logic [LINE_W-1:0] imem_wdata,
    output logic [LINE_W-1:0] imem_rdata,
    output logic              imem_resp,
    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic [ADDR_W-1:0] dmem_address,
    input  logic [LINE_W-1:0] dmem_wdata,
    output logic [LINE_W-1:0] dmem_rdata,
    output logic              dmem_resp,
    output logic              mmem_read,
    output logic              mmem_write,
    output logic [ADDR_W-1:0] mmem_address,
    output logic [LINE_W-1:0] mmem_wdata,
    input  logic [LINE_W-1:0] mmem_rdata,
    input  logic              mmem_resp
);

    // A zero limit still needs a one-bit counter so the declaration stays legal.
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
    localparam bit PREF_D = (PRIO_D != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } state_t;

    state_t          state;
    logic [SW-1:0]   starve_cnt;

    logic i_req;
    logic d_req;
    logic contend;
    logic starved;
    logic grant_d;
    logic pref_won;

    assign i_req    = imem_read | imem_write;
    assign d_req    = dmem_read | dmem_write;
    assign contend  = i_req & d_req;
    assign starved  = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);
    // Under contention the preferred side wins unless the other side has waited out the limit.
    assign grant_d  = d_req & (~i_req | (PREF_D ? ~starved : starved));
    assign pref_won = contend & (grant_d == PREF_D);

    // Arbitration FSM with all downstream and response outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            imem_resp    <= 1'b0;
            dmem_resp    <= 1'b0;
            mmem_read    <= 1'b0;
            mmem_write   <= 1'b0;
            mmem_address <= '0;
            mmem_wdata   <= '0;
            imem_rdata   <= '0;
            dmem_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        // Write takes precedence when a side raises read and write together.
                        if (grant_d) begin
                            mmem_address <= dmem_address;
                            mmem_wdata   <= dmem_wdata;
                            mmem_write   <= dmem_write;
                            mmem_read    <= ~dmem_write;
                            state        <= BUSY_D;
                        end else begin
                            mmem_address <= imem_address;
                            mmem_wdata   <= imem_wdata;
                            mmem_write   <= imem_write;
                            mmem_read    <= ~imem_write;
                            state        <= BUSY_I;
                        end
                        if (pref_won) begin
                            if (starve_cnt != LIMIT) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end else begin
                            starve_cnt <= '0;
                        end
                    end
                end
                BUSY_I: begin
                    if (mmem_resp) begin
                        if (mmem_read) begin
                            imem_rdata <= mmem_rdata;
                        end
                        mmem_read  <= 1'b0;
                        mmem_write <= 1'b0;
                        imem_resp  <= 1'b1;
                        state      <= RESP_I;
                    end
                end
                BUSY_D: begin
                    if (mmem_resp) begin
                        if (mmem_read) begin
                            dmem_rdata <= mmem_rdata;
                        end
                        mmem_read  <= 1'b0;
                        mmem_write <= 1'b0;
                        dmem_resp  <= 1'b1;
                        state      <= RESP_D;
                    end
                end
                RESP_I: begin
                    imem_resp <= 1'b0;
                    state     <= IDLE;
                end
                RESP_D: begin
                    dmem_resp <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// Bench for mem_arbiter_fsm: directed scenarios plus a mixed two-sided run against a line memory model.
// The adaptor is modelled by a responder process with programmable latency.
// All DUT outputs are sampled on the falling edge.
module tb_mem_arbiter_fsm;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          imem_read = 1'b0, imem_write = 1'b0;
    logic [AW-1:0] imem_address = '0;
    logic [LW-1:0] imem_wdata = '0;
    logic [LW-1:0] imem_rdata;
    logic          imem_resp;
    logic          dmem_read = 1'b0, dmem_write = 1'b0;
    logic [AW-1:0] dmem_address = '0;
    logic [LW-1:0] dmem_wdata = '0;
    logic [LW-1:0] dmem_rdata;
    logic          dmem_resp;
    logic          mmem_read, mmem_write;
    logic [AW-1:0] mmem_address;
    logic [LW-1:0] mmem_wdata;
    logic [LW-1:0] mmem_rdata = '0;
    logic          mmem_resp = 1'b0;

    int total = 0;
    int bad = 0;
    int lat = 2;
    bit resp_en = 1'b1;
    bit rnd_lat = 1'b0;
    bit mon_on = 1'b0;
    int wcnt = 0;
    int i_resp_n = 0;
    int d_resp_n = 0;

    logic [LW-1:0] mem [logic [AW-1:0]];
    logic [LW-1:0] ref_mem [logic [AW-1:0]];

    mem_arbiter_fsm #(.LINE_W(LW), .ADDR_W(AW), .PRIO_D(1), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_read(imem_read), .imem_write(imem_write), .imem_address(imem_address),
        .imem_wdata(imem_wdata), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .mmem_read(mmem_read), .mmem_write(mmem_write), .mmem_address(mmem_address),
        .mmem_wdata(mmem_wdata), .mmem_rdata(mmem_rdata), .mmem_resp(mmem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] initval(input logic [AW-1:0] a);
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    function automatic logic [LW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : initval(a);
    endfunction

    // Adaptor model: answers a held request after lat cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_en) begin
                mmem_resp = 1'b0;
                if (mmem_read || mmem_write) begin
                    if (wcnt >= lat - 1) begin
                        mmem_resp = 1'b1;
                        wcnt = 0;
                        if (mmem_write) mem[mmem_address] = mmem_wdata;
                        else mmem_rdata = mem.exists(mmem_address) ? mem[mmem_address] : initval(mmem_address);
                        if (rnd_lat) lat = $urandom_range(1, 4);
                    end else begin
                        wcnt++;
                    end
                end else begin
                    wcnt = 0;
                end
            end
        end
    end

    // Protocol monitor for the mixed run.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                total++; if (imem_resp && dmem_resp) begin bad++; $display("FAIL mon_resp_onehot: got i=%0b d=%0b want not both", imem_resp, dmem_resp); end
                total++; if (mmem_read && mmem_write) begin bad++; $display("FAIL mon_rw_onehot: got rd=%0b wr=%0b want not both", mmem_read, mmem_write); end
                if (imem_resp) i_resp_n++;
                if (dmem_resp) d_resp_n++;
            end
        end
    end

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++; if (mmem_read !== 1'b0) begin bad++; $display("FAIL rst_mmem_read: got %0b want 0", mmem_read); end
        total++; if (mmem_write !== 1'b0) begin bad++; $display("FAIL rst_mmem_write: got %0b want 0", mmem_write); end
        total++; if (mmem_address !== '0) begin bad++; $display("FAIL rst_mmem_address: got %0h want 0", mmem_address); end
        total++; if (mmem_wdata !== '0) begin bad++; $display("FAIL rst_mmem_wdata: got %0h want 0", mmem_wdata); end
        total++; if (imem_resp !== 1'b0 || dmem_resp !== 1'b0) begin bad++; $display("FAIL rst_resp: got i=%0b d=%0b want 0 0", imem_resp, dmem_resp); end
        total++; if (imem_rdata !== '0 || dmem_rdata !== '0) begin bad++; $display("FAIL rst_rdata: got i=%0h d=%0h want 0 0", imem_rdata, dmem_rdata); end
        total++; if (dut.starve_cnt !== '0) begin bad++; $display("FAIL rst_starve_cnt: got %0d want 0", dut.starve_cnt); end
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (mmem_read !== 1'b0 || imem_resp !== 1'b0) begin bad++; $display("FAIL rst_idle: got rd=%0b iresp=%0b want 0 0", mmem_read, imem_resp); end
    endtask

    task automatic test_i_read;
        logic [AW-1:0] a;
        logic [LW-1:0] exp;
        a = 32'h0000_1040;
        exp = initval(a);
        lat = 5;
        @(negedge clk);
        imem_read = 1'b1; imem_address = a;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            total++; if (mmem_read !== 1'b1 || mmem_address !== a) begin bad++; $display("FAIL iread_busy c%0d: got rd=%0b addr=%0h want 1 %0h", c, mmem_read, mmem_address, a); end
            total++; if (imem_resp !== 1'b0) begin bad++; $display("FAIL iread_early_resp c%0d: got %0b want 0", c, imem_resp); end
        end
        @(negedge clk);
        total++; if (imem_resp !== 1'b1 || mmem_read !== 1'b0) begin bad++; $display("FAIL iread_resp c6: got resp=%0b rd=%0b want 1 0", imem_resp, mmem_read); end
        total++; if (imem_rdata !== exp) begin bad++; $display("FAIL iread_data: got %0h want %0h", imem_rdata, exp); end
        imem_read = 1'b0;
        @(negedge clk);
        total++; if (imem_resp !== 1'b0) begin bad++; $display("FAIL iread_pulse c7: got %0b want 0", imem_resp); end
        lat = 2;
    endtask

    task automatic test_prio;
        logic [AW-1:0] ia, da;
        logic [LW-1:0] wd;
        bit got;
        ia = 32'h0000_1100; da = 32'h0000_2100;
        wd = {8{32'hDEAD_BEEF}};
        @(negedge clk);
        imem_read = 1'b1; imem_address = ia;
        dmem_write = 1'b1; dmem_address = da; dmem_wdata = wd;
        @(negedge clk);
        total++; if (mmem_write !== 1'b1 || mmem_read !== 1'b0) begin bad++; $display("FAIL prio_d_first: got wr=%0b rd=%0b want 1 0", mmem_write, mmem_read); end
        total++; if (mmem_address !== da || mmem_wdata !== wd) begin bad++; $display("FAIL prio_d_payload: got addr=%0h wdata=%0h want %0h %0h", mmem_address, mmem_wdata, da, wd); end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin @(negedge clk); got = dmem_resp; end
        total++; if (!got || imem_resp !== 1'b0) begin bad++; $display("FAIL prio_dresp: got dresp=%0b iresp=%0b want 1 0", got, imem_resp); end
        dmem_write = 1'b0;
        ref_mem[da] = wd;
        @(negedge clk);
        total++; if (mmem_read !== 1'b0 || mmem_write !== 1'b0) begin bad++; $display("FAIL prio_gap: got rd=%0b wr=%0b want 0 0", mmem_read, mmem_write); end
        @(negedge clk);
        total++; if (mmem_read !== 1'b1 || mmem_address !== ia) begin bad++; $display("FAIL prio_i_next: got rd=%0b addr=%0h want 1 %0h", mmem_read, mmem_address, ia); end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin @(negedge clk); got = imem_resp; end
        total++; if (!got || imem_rdata !== initval(ia)) begin bad++; $display("FAIL prio_iresp: got resp=%0b data=%0h want 1 %0h", got, imem_rdata, initval(ia)); end
        imem_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_starve;
        int d_cnt;
        bit got_i;
        d_cnt = 0; got_i = 1'b0;
        @(negedge clk);
        imem_read = 1'b1; imem_address = 32'h0000_1200;
        dmem_read = 1'b1; dmem_address = 32'h0000_2200;
        for (int c = 0; c < 100 && !got_i; c++) begin
            @(negedge clk);
            if (dmem_resp) d_cnt++;
            got_i = imem_resp;
        end
        total++; if (!got_i || d_cnt != 4) begin bad++; $display("FAIL starve_grants: got i_served=%0b d_before_i=%0d want 1 4", got_i, d_cnt); end
        total++; if (dut.starve_cnt !== '0) begin bad++; $display("FAIL starve_cnt_clear: got %0d want 0", dut.starve_cnt); end
        total++; if (imem_rdata !== initval(32'h0000_1200)) begin bad++; $display("FAIL starve_idata: got %0h want %0h", imem_rdata, initval(32'h0000_1200)); end
        imem_read = 1'b0; dmem_read = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        resp_en = 1'b0;
        @(negedge clk);
        dmem_write = 1'b1; dmem_address = 32'h0000_2300; dmem_wdata = {8{32'h1234_5678}};
        @(negedge clk);
        total++; if (mmem_write !== 1'b1) begin bad++; $display("FAIL rmid_busy: got wr=%0b want 1", mmem_write); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (mmem_write !== 1'b0 || mmem_address !== '0) begin bad++; $display("FAIL rmid_async: got wr=%0b addr=%0h want 0 0", mmem_write, mmem_address); end
        @(negedge clk);
        dmem_write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (dmem_resp !== 1'b0 || mmem_write !== 1'b0 || mmem_read !== 1'b0) begin bad++; $display("FAIL rmid_idle c%0d: got dresp=%0b wr=%0b rd=%0b want 0 0 0", c, dmem_resp, mmem_write, mmem_read); end
        end
        total++; if (dmem_rdata !== '0) begin bad++; $display("FAIL rmid_rdata: got %0h want 0", dmem_rdata); end
        resp_en = 1'b1;
    endtask

    task automatic test_spurious;
        resp_en = 1'b0;
        @(negedge clk);
        mmem_resp = 1'b1; mmem_rdata = {8{32'hBAD0_BAD0}};
        @(negedge clk);
        mmem_resp = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++; if (imem_resp !== 1'b0 || dmem_resp !== 1'b0) begin bad++; $display("FAIL spur_resp c%0d: got i=%0b d=%0b want 0 0", c, imem_resp, dmem_resp); end
        end
        total++; if (imem_rdata !== '0 || dmem_rdata !== '0) begin bad++; $display("FAIL spur_rdata: got i=%0h d=%0h want 0 0", imem_rdata, dmem_rdata); end
        resp_en = 1'b1;
    endtask

    task automatic test_rw_both;
        logic [AW-1:0] a;
        logic [LW-1:0] w;
        bit got;
        a = 32'h0000_2400; w = {8{32'hA11C_E5ED}};
        @(negedge clk);
        dmem_read = 1'b1; dmem_write = 1'b1; dmem_address = a; dmem_wdata = w;
        @(negedge clk);
        total++; if (mmem_write !== 1'b1 || mmem_read !== 1'b0) begin bad++; $display("FAIL rw_as_write: got wr=%0b rd=%0b want 1 0", mmem_write, mmem_read); end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin @(negedge clk); got = dmem_resp; end
        total++; if (!got || dmem_rdata !== '0) begin bad++; $display("FAIL rw_wresp: got resp=%0b rdata=%0h want 1 0", got, dmem_rdata); end
        ref_mem[a] = w;
        dmem_read = 1'b0; dmem_write = 1'b0;
        @(negedge clk);
        dmem_read = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin @(negedge clk); got = dmem_resp; end
        total++; if (!got || dmem_rdata !== w) begin bad++; $display("FAIL rw_readback: got resp=%0b data=%0h want 1 %0h", got, dmem_rdata, w); end
        dmem_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic side_run(input bit is_d, input int n);
        logic [AW-1:0] a;
        logic [LW-1:0] w, exp, rd;
        bit we, got;
        for (int k = 0; k < n; k++) begin
            a = (is_d ? 32'h0000_0200 : 32'h0000_0100) + 32'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            exp = ref_rd(a);
            if (is_d) begin dmem_read = ~we; dmem_write = we; dmem_address = a; dmem_wdata = w; end
            else begin imem_read = ~we; imem_write = we; imem_address = a; imem_wdata = w; end
            got = 1'b0;
            for (int c = 0; c < 300 && !got; c++) begin
                @(negedge clk);
                got = is_d ? dmem_resp : imem_resp;
            end
            rd = is_d ? dmem_rdata : imem_rdata;
            total++;
            if (!got) begin bad++; $display("FAIL rnd_timeout side%0d op%0d: got no resp want resp", is_d, k); end
            else if (!we && rd !== exp) begin bad++; $display("FAIL rnd_data side%0d op%0d addr %0h: got %0h want %0h", is_d, k, a, rd, exp); end
            if (we) ref_mem[a] = w;
            if (is_d) begin dmem_read = 1'b0; dmem_write = 1'b0; end
            else begin imem_read = 1'b0; imem_write = 1'b0; end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        i_resp_n = 0; d_resp_n = 0;
        rnd_lat = 1'b1;
        @(negedge clk);
        mon_on = 1'b1;
        fork
            side_run(1'b0, 500);
            side_run(1'b1, 500);
        join
        @(negedge clk);
        mon_on = 1'b0;
        rnd_lat = 1'b0;
        total++; if (i_resp_n != 500 || d_resp_n != 500) begin bad++; $display("FAIL rnd_resp_count: got i=%0d d=%0d want 500 500", i_resp_n, d_resp_n); end
    endtask

    initial begin
        test_reset;
        test_i_read;
        test_prio;
        test_starve;
        test_reset_mid;
        test_spurious;
        test_rw_both;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
